// File: rtl/pc_gen_ras.sv
// Next-PC generator for the fetch stage: redirect/stall arbitration, decode-stage
// early jumps, fence holds and a circular return-address stack for predicted returns.
module pc_gen_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned     INST_BYTES   = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         csr_redir,
  input  logic [XLEN-1:0]              csr_addr,
  input  logic                         ex_redir,
  input  logic                         ex_mispredict,
  input  logic [XLEN-1:0]              ex_target,
  input  logic [XLEN-1:0]              ex_saved_pc,
  input  logic                         early_jump,
  input  logic [XLEN-1:0]              early_offset,
  input  logic                         early_call,
  input  logic                         early_ret,
  input  logic                         stall,
  input  logic                         fence_hold,
  input  logic                         fetch_ready,
  output logic [XLEN-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ret_miss
);

  localparam int unsigned     PW    = $clog2(RAS_DEPTH);
  localparam int unsigned     CW    = PW + 1;
  localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN = ~(STEP - XLEN'(1));
  localparam logic [CW-1:0]   FULL  = CW'(RAS_DEPTH);

  typedef enum logic [3:0] {
    SEL_CSR,
    SEL_EX_FIX,
    SEL_EX_TGT,
    SEL_HOLD,
    SEL_POP,
    SEL_MISS,
    SEL_JUMP,
    SEL_FENCE,
    SEL_SEQ
  } sel_e;

  sel_e            sel;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_dec;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] ras_top;
  logic            push_en;
  logic            pop_en;

  assign ptr_dec = ptr - PW'(1);
  assign ras_top = ras[ptr_dec];

  always_comb begin
    sel = SEL_SEQ;
    if (csr_redir)                          sel = SEL_CSR;
    else if (ex_redir && ex_mispredict)     sel = SEL_EX_FIX;
    else if (ex_redir)                      sel = SEL_EX_TGT;
    else if (stall || !fetch_ready)         sel = SEL_HOLD;
    else if (early_ret && ras_count != '0)  sel = SEL_POP;
    else if (early_ret)                     sel = SEL_MISS;
    else if (early_jump)                    sel = SEL_JUMP;
    else if (fence_hold)                    sel = SEL_FENCE;
  end

  always_comb begin
    next_pc = pc + STEP;
    case (sel)
      SEL_CSR:              next_pc = csr_addr;
      SEL_EX_FIX:           next_pc = ex_saved_pc + STEP;
      SEL_EX_TGT:           next_pc = ex_target;
      SEL_HOLD, SEL_FENCE:  next_pc = pc;
      SEL_POP:              next_pc = ras_top;
      SEL_JUMP:             next_pc = pc + early_offset - STEP;
      default:              next_pc = pc + STEP;
    endcase
  end

  // A call on a return cycle is a coroutine swap: the push reuses the slot just popped.
  assign pop_en  = (sel == SEL_POP);
  assign push_en = early_call && (sel == SEL_JUMP || sel == SEL_POP || sel == SEL_MISS);
  assign wr_idx  = pop_en ? ptr_dec : ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      ptr       <= '0;
      ras_count <= '0;
      ret_miss  <= 1'b0;
    end else begin
      pc       <= next_pc & ALIGN;
      ret_miss <= (sel == SEL_MISS);
      if (push_en) begin
        ptr <= wr_idx + PW'(1);
        if (!pop_en && ras_count != FULL)
          ras_count <= ras_count + CW'(1);
      end else if (pop_en) begin
        ptr       <= ptr_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en)
      ras[wr_idx] <= pc;
  end

endmodule
